// File: rtl/object_pool.sv
// object_pool: shared motion engine for SLOTS projectile slots.
// Spawns fill the lowest free slot through a valid/ready handshake. Each motion
// tick starts a sweep that updates one slot per cycle, applies gravity, clamps
// the apex and retires off-screen slots. Slots can be killed by index, and the
// display path reads slot state through a registered index port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   tick                          one-cycle motion-tick pulse
//   spawn_valid/ready, spawn_*    spawn handshake and initial position/velocity
//   kill_valid, kill_idx          retire a slot by index
//   rd_idx -> rd_posx/posy/alive  registered slot readout (1-cycle latency)
//   alive                         live-slot bitmap
//   sweep_done, tick_overrun      end-of-sweep and dropped-tick pulses
module object_pool #(
  parameter int unsigned SLOTS   = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned SCR_W   = 640,
  parameter int unsigned SCR_H   = 480,
  parameter int unsigned GRAVITY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             spawn_valid,
  output logic             spawn_ready,
  input  logic [9:0]       spawn_x,
  input  logic [8:0]       spawn_y,
  input  logic [5:0]       spawn_vx,
  input  logic [7:0]       spawn_vy,
  input  logic             kill_valid,
  input  logic [IDX_W-1:0] kill_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [9:0]       rd_posx,
  output logic [8:0]       rd_posy,
  output logic             rd_alive,
  output logic [SLOTS-1:0] alive,
  output logic             sweep_done,
  output logic             tick_overrun
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] UPDATE = 1'b1;

  localparam logic signed [11:0] X_MAX    = 12'(SCR_W - 1);
  localparam logic signed [11:0] Y_MAX    = 12'(SCR_H - 1);
  localparam logic signed [11:0] GRAV_EXT = 12'(GRAVITY);
  localparam logic signed [11:0] VY_SAT   = 12'sd127;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(SLOTS - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [SLOTS-1:0] alive_q, alive_d;
  logic [9:0]       x_q  [SLOTS];
  logic [9:0]       x_d  [SLOTS];
  logic [8:0]       y_q  [SLOTS];
  logic [8:0]       y_d  [SLOTS];
  logic [5:0]       vx_q [SLOTS];
  logic [5:0]       vx_d [SLOTS];
  logic [7:0]       vy_q [SLOTS];
  logic [7:0]       vy_d [SLOTS];
  logic [9:0]       rd_posx_q, rd_posx_d;
  logic [8:0]       rd_posy_q, rd_posy_d;
  logic             rd_alive_q, rd_alive_d;
  logic             sweep_done_q, sweep_done_d;
  logic             overrun_q, overrun_d;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic signed [11:0] nx, ny, nvy;
  logic [7:0]       nvy_sat;
  logic             retire;

  // Slot arithmetic for the slot currently addressed by the sweep
  always_comb begin
    nx      = $signed({2'b00, x_q[idx_q]}) + $signed({{6{vx_q[idx_q][5]}}, vx_q[idx_q]});
    ny      = $signed({3'b000, y_q[idx_q]}) + $signed({{4{vy_q[idx_q][7]}}, vy_q[idx_q]});
    nvy     = $signed({{4{vy_q[idx_q][7]}}, vy_q[idx_q]}) + GRAV_EXT;
    nvy_sat = (nvy > VY_SAT) ? 8'd127 : nvy[7:0];
    retire  = nx[11] || (nx > X_MAX) || (ny > Y_MAX);
  end

  // Lowest free slot, taken from the bitmap at the start of the cycle
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (!alive_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state logic: sweep FSM, kill, spawn and readout
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    alive_d      = alive_q;
    x_d          = x_q;
    y_d          = y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    sweep_done_d = 1'b0;
    overrun_d    = 1'b0;
    spawn_ready  = (state_q == IDLE) && !pend_q && free_found && !rst;

    case (state_q)
      IDLE: begin
        // A tick coinciding with a pending tick is absorbed into one sweep
        if (tick || pend_q) begin
          state_d   = UPDATE;
          idx_d     = '0;
          pend_d    = 1'b0;
          overrun_d = tick && pend_q;
        end
      end
      UPDATE: begin
        if (alive_q[idx_q]) begin
          x_d[idx_q]     = nx[9:0];
          alive_d[idx_q] = !retire;
          if (ny[11] && !retire) begin
            y_d[idx_q]  = '0;
            vy_d[idx_q] = '0;
          end else begin
            y_d[idx_q]  = ny[8:0];
            vy_d[idx_q] = nvy_sat;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d      = IDLE;
          sweep_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (tick) begin
          if (pend_q) overrun_d = 1'b1;
          else        pend_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Kill overrides the sweep write; spawn targets a slot that was already dead
    if (kill_valid && (32'(kill_idx) < SLOTS)) alive_d[kill_idx] = 1'b0;

    if (spawn_valid && spawn_ready) begin
      alive_d[free_idx] = 1'b1;
      x_d[free_idx]     = spawn_x;
      y_d[free_idx]     = spawn_y;
      vx_d[free_idx]    = spawn_vx;
      vy_d[free_idx]    = spawn_vy;
    end

    if (32'(rd_idx) < SLOTS) begin
      rd_posx_d  = x_q[rd_idx];
      rd_posy_d  = y_q[rd_idx];
      rd_alive_d = alive_q[rd_idx];
    end else begin
      rd_posx_d  = '0;
      rd_posy_d  = '0;
      rd_alive_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      alive_q      <= '0;
      rd_posx_q    <= '0;
      rd_posy_q    <= '0;
      rd_alive_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      alive_q      <= alive_d;
      rd_posx_q    <= rd_posx_d;
      rd_posy_q    <= rd_posy_d;
      rd_alive_q   <= rd_alive_d;
      sweep_done_q <= sweep_done_d;
      overrun_q    <= overrun_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
    end
  end

  assign rd_posx      = rd_posx_q;
  assign rd_posy      = rd_posy_q;
  assign rd_alive     = rd_alive_q;
  assign alive        = alive_q;
  assign sweep_done   = sweep_done_q;
  assign tick_overrun = overrun_q;

endmodule
